fa_resp_checker: RTL

FA_RESP_CHECKER -- requirements
Module: fa_resp_checker

---
 rtl/fa_resp_checker.sv | 67 ++++++
 1 files changed

// File: rtl/fa_resp_checker.sv
// fa_resp_checker: checks a 1-bit full adder's responses over a run of N_VEC samples, tracking errors and input coverage
module fa_resp_checker #(
    parameter int N_VEC = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             sum,
    input  logic             carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       cov,
    output logic [2:0]       first_err_vec,
    output logic             first_err_valid
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t     state, state_nx;
    logic [7:0] smp_cnt;
    logic [2:0] vec;
    logic       exp_sum, exp_carry, mis, chk, clr, last;
    assign vec       = {a, b, c};
    assign exp_sum   = a ^ b ^ c;
    assign exp_carry = (a & b) | (b & c) | (a & c);
    assign mis       = (sum !== exp_sum) || (carry !== exp_carry);
    assign chk       = (state == RUN) && in_valid;
    assign clr       = (state != RUN) && start;
    assign last      = smp_cnt == 8'(N_VEC - 1);
    // next state and status outputs; the run ends on the edge that checks the last sample
    always_comb begin
        state_nx = clr ? RUN : (chk && last) ? DONE : state;
        busy     = state == RUN;
        done     = state == DONE;
        pass     = done && (err_cnt == '0) && (cov == 8'hFF);
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // run statistics: cleared on reset or a new start, updated by each checked sample
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            smp_cnt         <= '0;
            err_cnt         <= '0;
            cov             <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
        end else if (chk) begin
            smp_cnt  <= smp_cnt + 8'd1;
            cov[vec] <= 1'b1;
            if (mis) begin
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                if (!first_err_valid) begin
                    first_err_vec   <= vec;
                    first_err_valid <= 1'b1;
                end
            end
        end
    end
endmodule
